// File: rtl/operand_matcher_pkg.sv
// Shared definitions for the operand matching stage: stream widths,
// destination options, request field positions, FSM states and the
// matched-token builder used by both the design and its bench.
package operand_matcher_pkg;

   localparam int PACKET_REQUEST_WIDTH = 99;
   localparam int MATCHED_TOKEN_WIDTH  = 96;

   localparam int OPT_W   = 3;
   localparam int ADDR_W  = 16;
   localparam int COLOR_W = 16;
   localparam int DATA_W  = 32;

   localparam logic [OPT_W-1:0] DEST_OPTION_NOP   = 3'd0;
   localparam logic [OPT_W-1:0] DEST_OPTION_ONE   = 3'd1;
   localparam logic [OPT_W-1:0] DEST_OPTION_LEFT  = 3'd2;
   localparam logic [OPT_W-1:0] DEST_OPTION_RIGHT = 3'd3;

   // Packet request field positions (LSB of each field)
   localparam int PR_OPT_LSB   = 96;
   localparam int PR_ADDR_LSB  = 80;
   localparam int PR_COLOR_LSB = 64;
   localparam int PR_DATA1_LSB = 32;
   localparam int PR_DATA2_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MATCH,
      ST_SEND
   } state_t;

   function automatic logic [MATCHED_TOKEN_WIDTH-1:0] make_matched_token(
      input logic [ADDR_W-1:0]  dest_addr,
      input logic [COLOR_W-1:0] color,
      input logic [DATA_W-1:0]  left,
      input logic [DATA_W-1:0]  right
   );
      return {dest_addr, color, left, right};
   endfunction

endpackage

// File: rtl/operand_matcher_matching_table.sv
// Fully-associative table of pending half-pairs. Holds side, key and
// data1 for each waiting operand, compares the lookup key against every
// entry in parallel, allocates into the lowest free slot and tracks the
// number of valid entries.
module matching_table
   import operand_matcher_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [ADDR_W-1:0]  lookup_addr,
   input  logic [COLOR_W-1:0] lookup_color,
   output logic               hit,
   output logic               hit_side,
   output logic [DATA_W-1:0]  hit_data,
   output logic               full,
   input  logic               alloc,
   input  logic               alloc_side,
   input  logic [DATA_W-1:0]  alloc_data,
   input  logic               invalidate,
   output logic [CNT_W-1:0]   occupancy
);

   logic [ENTRIES-1:0] valid_reg;
   logic [ENTRIES-1:0] valid_next;
   logic [ENTRIES-1:0] side_reg;
   logic [ADDR_W-1:0]  addr_reg  [ENTRIES];
   logic [COLOR_W-1:0] color_reg [ENTRIES];
   logic [DATA_W-1:0]  data_reg  [ENTRIES];
   logic [CNT_W-1:0]   occupancy_reg;
   logic [CNT_W-1:0]   occupancy_next;

   logic [ENTRIES-1:0] match_vec;
   logic [ENTRIES-1:0] free_vec;
   logic [ENTRIES-1:0] free_onehot;

   // Parallel key compare; keys are unique so match_vec is at most one-hot
   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign match_vec[gi] = valid_reg[gi]
                             && (addr_reg[gi] == lookup_addr)
                             && (color_reg[gi] == lookup_color);
   end

   assign hit       = |match_vec;
   assign hit_side  = |(match_vec & side_reg);
   assign full      = &valid_reg;
   assign occupancy = occupancy_reg;

   // Lowest-index free slot as a one-hot mask (isolate lowest set bit)
   assign free_vec    = ~valid_reg;
   assign free_onehot = free_vec & (~free_vec + {{(ENTRIES-1){1'b0}}, 1'b1});

   // Select data of the single hitting entry by OR-reduction of masked entries
   always_comb begin
      hit_data = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (match_vec[i]) begin
            hit_data = hit_data | data_reg[i];
         end
      end
   end

   // Next valid mask and occupancy; alloc and invalidate are mutually exclusive
   always_comb begin
      valid_next     = valid_reg;
      occupancy_next = occupancy_reg;
      if (alloc) begin
         valid_next     = valid_reg | free_onehot;
         occupancy_next = occupancy_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (invalidate) begin
         valid_next     = valid_reg & ~match_vec;
         occupancy_next = occupancy_reg - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Valid bits and occupancy counter, cleared by reset
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg     <= '0;
         occupancy_reg <= '0;
      end else begin
         valid_reg     <= valid_next;
         occupancy_reg <= occupancy_next;
      end
   end

   // Entry payload; contents are meaningless while the valid bit is clear
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (alloc && free_onehot[i]) begin
            side_reg[i]  <= alloc_side;
            addr_reg[i]  <= lookup_addr;
            color_reg[i] <= lookup_color;
            data_reg[i]  <= alloc_data;
         end
      end
   end

endmodule

// File: rtl/operand_matcher.sv
// Operand matching stage: accepts packet requests, pairs LEFT/RIGHT
// operands sharing (dest_addr, color), forwards ONE requests, drops NOPs,
// and emits one matched token per completed operand set.
module operand_matcher
   import operand_matcher_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            RECEIVE_PR_VALID,
   input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR_DATA,
   output logic                            RECEIVE_PR_READY,
   output logic                            SEND_MT_VALID,
   output logic [MATCHED_TOKEN_WIDTH-1:0]  SEND_MT_DATA,
   input  logic                            SEND_MT_READY,
   output logic [CNT_W-1:0]                OCCUPANCY,
   output logic                            OVERFLOW,
   output logic                            PROTO_ERR
);

   state_t                          state_reg;
   logic [PACKET_REQUEST_WIDTH-1:0] hold_reg;
   logic                            mt_valid_reg;
   logic [MATCHED_TOKEN_WIDTH-1:0]  mt_data_reg;
   logic                            overflow_reg;
   logic                            proto_err_reg;

   logic [OPT_W-1:0]   hold_opt;
   logic [ADDR_W-1:0]  hold_addr;
   logic [COLOR_W-1:0] hold_color;
   logic [DATA_W-1:0]  hold_data1;
   logic [DATA_W-1:0]  hold_data2;
   logic               hold_side;
   logic               hold_is_pair;

   logic               tbl_hit;
   logic               tbl_hit_side;
   logic [DATA_W-1:0]  tbl_hit_data;
   logic               tbl_full;
   logic               tbl_alloc;
   logic               tbl_invalidate;
   logic               in_match;

   assign hold_opt   = hold_reg[PR_OPT_LSB   +: OPT_W];
   assign hold_addr  = hold_reg[PR_ADDR_LSB  +: ADDR_W];
   assign hold_color = hold_reg[PR_COLOR_LSB +: COLOR_W];
   assign hold_data1 = hold_reg[PR_DATA1_LSB +: DATA_W];
   assign hold_data2 = hold_reg[PR_DATA2_LSB +: DATA_W];

   // Side bit: 0 = LEFT, 1 = RIGHT
   assign hold_side    = (hold_opt == DEST_OPTION_RIGHT);
   assign hold_is_pair = (hold_opt == DEST_OPTION_LEFT) || (hold_opt == DEST_OPTION_RIGHT);
   assign in_match     = (state_reg == ST_MATCH);

   // Table writes happen only in MATCH, so SEND never disturbs the table
   assign tbl_invalidate = in_match && hold_is_pair && tbl_hit && (tbl_hit_side != hold_side);
   assign tbl_alloc      = in_match && hold_is_pair && !tbl_hit && !tbl_full;

   // Ready is gated by reset so it reads 0 during reset and 1 right after
   assign RECEIVE_PR_READY = (state_reg == ST_IDLE) && !RST;
   assign SEND_MT_VALID    = mt_valid_reg;
   assign SEND_MT_DATA     = mt_data_reg;
   assign OVERFLOW         = overflow_reg;
   assign PROTO_ERR        = proto_err_reg;

   matching_table #(
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) u_table (
      .clk          (CLK),
      .srst         (RST),
      .lookup_addr  (hold_addr),
      .lookup_color (hold_color),
      .hit          (tbl_hit),
      .hit_side     (tbl_hit_side),
      .hit_data     (tbl_hit_data),
      .full         (tbl_full),
      .alloc        (tbl_alloc),
      .alloc_side   (hold_side),
      .alloc_data   (hold_data1),
      .invalidate   (tbl_invalidate),
      .occupancy    (OCCUPANCY)
   );

   // Control FSM with registered token output and sticky error flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= ST_IDLE;
         hold_reg      <= '0;
         mt_valid_reg  <= 1'b0;
         mt_data_reg   <= '0;
         overflow_reg  <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (RECEIVE_PR_VALID) begin
                  hold_reg  <= RECEIVE_PR_DATA;
                  state_reg <= ST_MATCH;
               end
            end
            ST_MATCH: begin
               state_reg <= ST_IDLE;
               case (hold_opt)
                  DEST_OPTION_ONE: begin
                     mt_data_reg  <= make_matched_token(hold_addr, hold_color,
                                                        hold_data1, hold_data2);
                     mt_valid_reg <= 1'b1;
                     state_reg    <= ST_SEND;
                  end
                  DEST_OPTION_NOP: begin
                  end
                  DEST_OPTION_LEFT, DEST_OPTION_RIGHT: begin
                     if (tbl_hit) begin
                        if (tbl_hit_side != hold_side) begin
                           // Place operands by side, not by arrival order
                           if (hold_side) begin
                              mt_data_reg <= make_matched_token(hold_addr, hold_color,
                                                                tbl_hit_data, hold_data1);
                           end else begin
                              mt_data_reg <= make_matched_token(hold_addr, hold_color,
                                                                hold_data1, tbl_hit_data);
                           end
                           mt_valid_reg <= 1'b1;
                           state_reg    <= ST_SEND;
                        end else begin
                           proto_err_reg <= 1'b1;
                        end
                     end else if (tbl_full) begin
                        overflow_reg <= 1'b1;
                     end
                  end
                  default: begin
                     proto_err_reg <= 1'b1;
                  end
               endcase
            end
            ST_SEND: begin
               if (SEND_MT_READY) begin
                  mt_valid_reg <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_matcher.sv
// Directed bench for operand_matcher: pairing in both orders, ONE/NOP,
// key isolation, duplicates, reserved options, overflow with slot reuse,
// output backpressure and reset behaviour.
module tb_operand_matcher;
   import operand_matcher_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pr_valid = 1'b0;
   logic [98:0]  pr_data = '0;
   logic         pr_ready;
   logic         mt_valid;
   logic [95:0]  mt_data;
   logic         mt_ready = 1'b1;
   logic [3:0]   occupancy;
   logic         overflow;
   logic         proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   operand_matcher #(.ENTRIES(8), .CNT_W(4)) dut (
      .CLK              (clk),
      .RST              (rst),
      .RECEIVE_PR_VALID (pr_valid),
      .RECEIVE_PR_DATA  (pr_data),
      .RECEIVE_PR_READY (pr_ready),
      .SEND_MT_VALID    (mt_valid),
      .SEND_MT_DATA     (mt_data),
      .SEND_MT_READY    (mt_ready),
      .OCCUPANCY        (occupancy),
      .OVERFLOW         (overflow),
      .PROTO_ERR        (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one request and hold it until accepted; returns in the MATCH cycle
   task automatic send_req(input string tag, input logic [2:0] opt, input logic [15:0] addr,
                           input logic [15:0] color, input logic [31:0] d1, input logic [31:0] d2);
      int waits;
      pr_valid = 1'b1;
      pr_data  = {opt, addr, color, d1, d2};
      waits = 0;
      while (!pr_ready && waits < 20) begin
         tick();
         waits++;
      end
      check({tag, "_accept"}, {95'd0, pr_ready}, 96'd1);
      tick();
      pr_valid = 1'b0;
      $display("req  %s opt=%0d addr=%h color=%h d1=%h", tag, opt, addr, color, d1);
   endtask

   // Request that must not emit: READY back and no token two cycles after handshake
   task automatic expect_quiet(input string tag, input logic [3:0] exp_occ);
      tick();
      check({tag, "_ready"}, {95'd0, pr_ready}, 96'd1);
      check({tag, "_novalid"}, {95'd0, mt_valid}, 96'd0);
      check({tag, "_occ"}, {92'd0, occupancy}, {92'd0, exp_occ});
   endtask

   // Expect a token in the cycle after MATCH, then let it drain (sink ready)
   task automatic expect_token(input string tag, input logic [95:0] exp);
      int waits;
      waits = 0;
      while (!mt_valid && waits < 10) begin
         tick();
         waits++;
      end
      check({tag, "_latency"}, 96'(waits), 96'd1);
      check({tag, "_data"}, mt_data, exp);
      $display("tok  %s data=%h", tag, mt_data);
      tick();
      check({tag, "_drop"}, {95'd0, mt_valid}, 96'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, {95'd0, pr_ready}, 96'd1);
      check({tag, "_valid"}, {95'd0, mt_valid}, 96'd0);
      check({tag, "_data"}, mt_data, 96'd0);
      check({tag, "_occ"}, {92'd0, occupancy}, 96'd0);
      check({tag, "_ovf"}, {95'd0, overflow}, 96'd0);
      check({tag, "_perr"}, {95'd0, proto_err}, 96'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      tick();
      check({tag, "_ready_in_rst"}, {95'd0, pr_ready}, 96'd0);
      rst = 1'b0;
      #1;
      check_reset_values(tag);
      $display("rst  %s", tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      do_reset("rst0");

      // Pair, left first
      send_req("pairL_l", DEST_OPTION_LEFT, 16'h0010, 16'h0003, 32'hAAAA0001, 32'hDEAD0000);
      expect_quiet("pairL_l", 4'd1);
      send_req("pairL_r", DEST_OPTION_RIGHT, 16'h0010, 16'h0003, 32'hBBBB0002, 32'hDEAD0001);
      expect_token("pairL", 96'h0010_0003_AAAA0001_BBBB0002);
      check("pairL_occ", {92'd0, occupancy}, 96'd0);

      // Pair, right first: identical token
      send_req("pairR_r", DEST_OPTION_RIGHT, 16'h0010, 16'h0003, 32'hBBBB0002, 32'h0);
      expect_quiet("pairR_r", 4'd1);
      send_req("pairR_l", DEST_OPTION_LEFT, 16'h0010, 16'h0003, 32'hAAAA0001, 32'h0);
      expect_token("pairR", 96'h0010_0003_AAAA0001_BBBB0002);
      check("pairR_occ", {92'd0, occupancy}, 96'd0);

      // ONE and NOP
      send_req("one", DEST_OPTION_ONE, 16'h0020, 16'h0001, 32'h00000011, 32'h00000022);
      expect_token("one", 96'h0020_0001_00000011_00000022);
      send_req("nop", DEST_OPTION_NOP, 16'h0030, 16'h0002, 32'h1, 32'h2);
      expect_quiet("nop", 4'd0);

      // Key isolation: same address, different color
      send_req("iso_l", DEST_OPTION_LEFT, 16'h0010, 16'h0001, 32'h0000A001, 32'h0);
      expect_quiet("iso_l", 4'd1);
      send_req("iso_r", DEST_OPTION_RIGHT, 16'h0010, 16'h0002, 32'h0000B002, 32'h0);
      expect_quiet("iso_r", 4'd2);
      check("iso_perr", {95'd0, proto_err}, 96'd0);

      // Duplicate LEFT on an existing key
      send_req("dup_l", DEST_OPTION_LEFT, 16'h0010, 16'h0001, 32'h0000A0FF, 32'h0);
      expect_quiet("dup_l", 4'd2);
      check("dup_perr", {95'd0, proto_err}, 96'd1);
      check("dup_ovf", {95'd0, overflow}, 96'd0);
      // Original entry survives the duplicate
      send_req("dup_r", DEST_OPTION_RIGHT, 16'h0010, 16'h0001, 32'h0000C003, 32'h0);
      expect_token("dup_pair", 96'h0010_0001_0000A001_0000C003);
      check("dup_pair_occ", {92'd0, occupancy}, 96'd1);

      do_reset("rst1");

      // Reserved option
      send_req("rsv", 3'd5, 16'h0040, 16'h0004, 32'h5, 32'h6);
      expect_quiet("rsv", 4'd0);
      check("rsv_perr", {95'd0, proto_err}, 96'd1);

      do_reset("rst2");

      // Fill the table with eight distinct LEFT keys
      for (int i = 0; i < 8; i++) begin
         send_req("fill", DEST_OPTION_LEFT, 16'h0100 + 16'(i), 16'h0000, 32'h10000000 + 32'(i), 32'h0);
         expect_quiet("fill", 4'(i + 1));
      end
      check("fill_ovf", {95'd0, overflow}, 96'd0);
      send_req("ovf", DEST_OPTION_LEFT, 16'h0200, 16'h0000, 32'h20000000, 32'h0);
      expect_quiet("ovf", 4'd8);
      check("ovf_flag", {95'd0, overflow}, 96'd1);
      send_req("ovf_r", DEST_OPTION_RIGHT, 16'h0100, 16'h0000, 32'h0000CAFE, 32'h0);
      expect_token("ovf_match", 96'h0100_0000_10000000_0000CAFE);
      check("ovf_match_occ", {92'd0, occupancy}, 96'd7);
      // Freed slot is reused
      send_req("reuse_l", DEST_OPTION_LEFT, 16'h0300, 16'h0000, 32'h00000033, 32'h0);
      expect_quiet("reuse_l", 4'd8);
      send_req("reuse_r", DEST_OPTION_RIGHT, 16'h0300, 16'h0000, 32'h00000044, 32'h0);
      expect_token("reuse", 96'h0300_0000_00000033_00000044);
      check("reuse_occ", {92'd0, occupancy}, 96'd7);

      // Backpressure: token held stable, input stalled
      mt_ready = 1'b0;
      send_req("bp", DEST_OPTION_ONE, 16'h0050, 16'h0005, 32'h00000055, 32'h00000066);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_valid", {95'd0, mt_valid}, 96'd1);
         check("bp_data", mt_data, 96'h0050_0005_00000055_00000066);
         check("bp_ready", {95'd0, pr_ready}, 96'd0);
         check("bp_occ", {92'd0, occupancy}, 96'd7);
      end
      mt_ready = 1'b1;
      tick();
      check("bp_drop", {95'd0, mt_valid}, 96'd0);
      check("bp_ready_back", {95'd0, pr_ready}, 96'd1);
      $display("tok  bp released");

      // Reset while a token is waiting
      mt_ready = 1'b0;
      send_req("midrst", DEST_OPTION_ONE, 16'h0060, 16'h0006, 32'h77, 32'h88);
      tick();
      check("midrst_valid_pre", {95'd0, mt_valid}, 96'd1);
      do_reset("rst3");
      mt_ready = 1'b1;
      tick();
      check("post_rst_valid", {95'd0, mt_valid}, 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/operand_matcher.md
# operand_matcher

Dataflow operand-matching stage that sits directly downstream of `function_expander` and consumes its packet-request stream. It pairs LEFT and RIGHT operand requests that share destination address and color, passes single-operand requests straight through, and drops NOP requests. Each completed operand set is emitted as one matched token toward instruction fetch. Pending half-pairs wait in a small fully-associative table.

## Interface
- `ENTRIES`, 8: pending-operand table depth; a power of two, minimum 2.
- `CNT_W`, $clog2(ENTRIES)+1: width of `OCCUPANCY`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `RECEIVE_PR_VALID` in 1: packet request valid.
- `RECEIVE_PR_DATA` in `PACKET_REQUEST_WIDTH` (99): packet request, fields MSB→LSB:
  - `dest_option[98:96]`
  - `dest_addr[95:80]`
  - `color[79:64]`
  - `data1[63:32]`
  - `data2[31:0]`
- `RECEIVE_PR_READY` out 1: request accepted on `VALID && READY`.
- `SEND_MT_VALID` out 1: matched token valid.
- `SEND_MT_DATA` out `MATCHED_TOKEN_WIDTH` (96): matched token, fields MSB→LSB:
  - `dest_addr[95:80]`
  - `color[79:64]`
  - `left[63:32]`
  - `right[31:0]`
- `SEND_MT_READY` in 1: downstream accepts on `VALID && READY`.
- `OCCUPANCY` out `CNT_W`: number of valid table entries.
- `OVERFLOW` out 1: sticky; set when a request was dropped because the table was full.
- `PROTO_ERR` out 1: sticky; set on a same-side duplicate or a reserved `dest_option`.

## Operation
- FSM with three states: IDLE, MATCH, SEND. Reset enters IDLE.
- **IDLE**
  - `RECEIVE_PR_READY`=1.
  - On handshake: latch the request into a holding register, go to MATCH.
- **MATCH** (exactly one cycle; `RECEIVE_PR_READY`=0). The action depends on `dest_option`:
  - **ONE:** load token `{dest_addr, color, data1, data2}` into the output register, go to SEND. The table is untouched.
  - **NOP:** discard the request, go to IDLE.
  - **LEFT or RIGHT:** search every valid entry for a key match on `(dest_addr, color)`.
  - **Hit, opposite side:** invalidate the entry and go to SEND. The token is `left` = data1 of the LEFT request and `right` = data1 of the RIGHT request, independent of arrival order.
  - **Hit, same side:** set `PROTO_ERR`, drop the request, keep the entry, go to IDLE.
  - **Miss, free entry available:** write `{side, dest_addr, color, data1}` into the lowest-index free entry, go to IDLE.
  - **Miss, table full:** set `OVERFLOW`, drop the request, go to IDLE.
  - **Reserved option (any other value):** set `PROTO_ERR`, drop the request, go to IDLE.
- **SEND**
  - `SEND_MT_VALID`=1 with `SEND_MT_DATA` stable until `SEND_MT_READY`.
  - On handshake: `SEND_MT_VALID`=0 next cycle, go to IDLE.
- Keys are unique by construction, so at most one entry can hit.
- `OCCUPANCY` is +1 on allocate and −1 on match-invalidate. Both never occur in the same cycle.
- `data2` of LEFT/RIGHT requests is ignored.

## Timing
- Reset values:
  - `RECEIVE_PR_READY`=0 while `RST`=1, and 1 in the first cycle after `RST` falls.
  - `SEND_MT_VALID`=0, `SEND_MT_DATA`=0.
  - `OCCUPANCY`=0, `OVERFLOW`=0, `PROTO_ERR`=0.
  - All entries are invalid.
- Latency:
  - Handshake at edge N → MATCH during cycle N+1 → `SEND_MT_VALID` high in cycle N+2.
  - Non-emitting requests: `READY` high again in cycle N+2.
- Throughput:
  - One emitting request per 3 cycles when the sink is always ready.
  - One non-emitting request per 2 cycles.
- Backpressure: `RECEIVE_PR_READY` stays 0 for the whole SEND stall. The table is never modified during SEND.
- `RST` mid-operation: abandons any held or output token, clears the table and sticky flags, and returns to IDLE on the next edge.
- The output is a registered source: `VALID` never drops before the handshake.

## Structure
- `param.vh` holds:
  - `PACKET_REQUEST_WIDTH`, `MATCHED_TOKEN_WIDTH`.
  - The shared `DEST_OPTION_NOP/ONE/LEFT/RIGHT` constants.
  - The field-position localparams.
- `construct.vh` gains a `make_matched_token(dest_addr, color, left, right)` function, used by RTL and bench.
- One sub-module, `matching_table`. It owns the entry array, the parallel key compare, the lowest-free priority encoder, and the occupancy count. It exposes:
  - `hit`, `hit_side`, `hit_data`, `full`
  - an `alloc` port
  - an `invalidate` port

## Test plan
- **Pair, left first:** LEFT(addr 0x0010, color 0x0003, data1 0xAAAA0001), then RIGHT(same key, 0xBBBB0002) → one token `{0x0010, 0x0003, 0xAAAA0001, 0xBBBB0002}`. `OCCUPANCY` goes 1→0.
- **Pair, right first:** send RIGHT before LEFT with the same values → an identical token (ordering independence).
- **ONE and NOP:**
  - ONE(0x0020, 0x0001, 0x11, 0x22) → token `{0x0020, 0x0001, 0x11, 0x22}` at handshake+2 cycles.
  - NOP → no token, `READY` back after 2 cycles.
- **Key isolation:** LEFT(0x0010, color 1) plus RIGHT(0x0010, color 2) → no token, `OCCUPANCY`=2.
- **Overflow:** 8 LEFTs with distinct keys, then a 9th distinct LEFT → `OVERFLOW`=1, `OCCUPANCY`=8. A RIGHT matching entry 0 then emits a token and `OCCUPANCY`=7.
- **Backpressure, errors and reset:**
  - Hold `SEND_MT_READY`=0 for 5 cycles → token stable and `RECEIVE_PR_READY`=0 throughout.
  - Duplicate LEFT → `PROTO_ERR`=1.
  - `RST` pulse → all outputs return to their reset values.
